// File: rtl/countdown_pkg.sv
// Shared types and width helpers for the countdown counter and its control stage.
package countdown_pkg;

    // Run controller states; encoding 2'd3 is illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } ctrl_state_t;

    // Bits needed for a counter that runs 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioning: 2-FF synchronizer, stability counter and press-edge detector.
// The accepted level only follows the pin after it has held a new value for DB_CYCLES cycles.
module button_debouncer
    import countdown_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press_pulse,
    output logic level
);

    localparam int unsigned   CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] DB_TERM = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    logic          w_level_d;
    logic          w_press_d;
    logic [CW-1:0] w_cnt_d;

    // Stability counter: restart while the pin agrees with the accepted level, accept on terminal.
    always_comb begin
        w_cnt_d   = r_cnt;
        w_level_d = r_level;
        w_press_d = 1'b0;
        if (r_sync2 == r_level) begin
            w_cnt_d = '0;
        end else if (r_cnt == DB_TERM) begin
            w_level_d = r_sync2;
            w_cnt_d   = '0;
            // Only the released->pressed transition is reported.
            w_press_d = ~r_sync2;
        end else begin
            w_cnt_d = r_cnt + CW'(1);
        end
    end

    // Synchronizer, accepted level and press pulse registers; idle state is "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            r_level <= w_level_d;
            r_press <= w_press_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign press_pulse = r_press;
    assign level       = r_level;

endmodule

// File: rtl/countdown_tick_ctrl.sv
// Control stage for the countdown counter: debounced run/clear keys, a run/pause controller,
// and a prescaler producing a one-cycle tick every CLK_DIV cycles while running.
module countdown_tick_ctrl
    import countdown_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 50_000_000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run_n,
    input  logic       btn_clear_n,
    output logic       tick,
    output logic       clear,
    output logic       running,
    output logic [1:0] state
);

    localparam int unsigned   PW         = cnt_width(CLK_DIV);
    localparam logic [PW-1:0] PRESC_TERM = PW'(CLK_DIV - 1);

    logic w_run_press;
    logic w_clear_press;
    logic w_run_level;
    logic w_clear_level;
    logic w_unused_levels;

    ctrl_state_t   r_state;
    ctrl_state_t   w_state_d;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_d;
    logic          r_tick;
    logic          w_tick_d;
    logic          r_clear;
    logic          w_clear_d;

    button_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_run_db (
        .clk         (clk),
        .reset       (reset),
        .btn_n       (btn_run_n),
        .press_pulse (w_run_press),
        .level       (w_run_level)
    );

    button_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_clear_db (
        .clk         (clk),
        .reset       (reset),
        .btn_n       (btn_clear_n),
        .press_pulse (w_clear_press),
        .level       (w_clear_level)
    );

    // Accepted levels are not needed here; only the press pulses drive the controller.
    assign w_unused_levels = w_run_level ^ w_clear_level;

    // Next state, prescaler and output pulses; a clear press overrides any run press.
    always_comb begin
        w_state_d = r_state;
        w_presc_d = r_presc;
        w_tick_d  = 1'b0;
        w_clear_d = 1'b0;
        if (w_clear_press) begin
            w_state_d = IDLE;
            w_presc_d = '0;
            w_clear_d = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_run_press) begin
                        w_state_d = RUN;
                        w_presc_d = '0;
                    end
                end
                RUN: begin
                    // The wrapping tick is still emitted when a pause arrives on the same cycle.
                    w_tick_d  = (r_presc == PRESC_TERM);
                    w_presc_d = (r_presc == PRESC_TERM) ? '0 : r_presc + PW'(1);
                    if (w_run_press) begin
                        w_state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    // Prescaler holds so the tick phase survives a pause.
                    if (w_run_press) begin
                        w_state_d = RUN;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                    w_presc_d = '0;
                end
            endcase
        end
    end

    // State, prescaler and registered tick/clear outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_presc <= w_presc_d;
            r_tick  <= w_tick_d;
            r_clear <= w_clear_d;
        end
    end

    assign tick    = r_tick;
    assign clear   = r_clear;
    assign state   = r_state;
    assign running = (r_state == RUN);

endmodule

// File: tb/tb_countdown_tick_ctrl.sv
// Bench for countdown_tick_ctrl: directed vector table, reset corner sequence, and randomized
// key activity, all checked every cycle against a behavioural model.
module tb_countdown_tick_ctrl;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned DB_CYCLES = 3;

    logic       clk         = 1'b0;
    logic       reset       = 1'b1;
    logic       btn_run_n   = 1'b1;
    logic       btn_clear_n = 1'b1;
    logic       tick;
    logic       clear;
    logic       running;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    int seg_ticks;
    int seg_clears;

    // Behavioural model: pins delayed two cycles through queues, debounce as a run length of
    // disagreeing cycles, and the tick phase as total cycles spent running.
    int m_state;
    int m_elapsed;
    bit m_tick;
    bit m_clear;
    bit m_acc[2];
    int m_mis[2];
    bit m_pend[2];
    bit m_hist0[$];
    bit m_hist1[$];

    typedef struct {
        bit run_n;
        bit clr_n;
        int cycles;
        int exp_state;
        int exp_ticks;
        int exp_clears;
    } vec_t;

    vec_t vecs[16];

    countdown_tick_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_run_n   (btn_run_n),
        .btn_clear_n (btn_clear_n),
        .tick        (tick),
        .clear       (clear),
        .running     (running),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_elapsed = 0;
        m_tick    = 1'b0;
        m_clear   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_acc[k]  = 1'b1;
            m_mis[k]  = 0;
            m_pend[k] = 1'b0;
        end
        m_hist0 = '{1'b1, 1'b1};
        m_hist1 = '{1'b1, 1'b1};
    endtask

    task automatic deb_step(input int k, input bit s);
        m_pend[k] = 1'b0;
        if (s == m_acc[k]) begin
            m_mis[k] = 0;
        end else begin
            m_mis[k]++;
            if (m_mis[k] == int'(DB_CYCLES)) begin
                m_acc[k]  = s;
                m_mis[k]  = 0;
                m_pend[k] = !s;
            end
        end
    endtask

    task automatic model_step();
        m_tick  = 1'b0;
        m_clear = 1'b0;
        if (m_pend[1]) begin
            m_state   = 0;
            m_elapsed = 0;
            m_clear   = 1'b1;
        end else if (m_state == 0) begin
            if (m_pend[0]) begin
                m_state   = 1;
                m_elapsed = 0;
            end
        end else if (m_state == 1) begin
            m_elapsed++;
            m_tick = (m_elapsed % int'(CLK_DIV)) == 0;
            if (m_pend[0]) m_state = 2;
        end else begin
            if (m_pend[0]) m_state = 1;
        end
        m_hist0.push_back(btn_run_n);
        m_hist1.push_back(btn_clear_n);
        deb_step(0, m_hist0.pop_front());
        deb_step(1, m_hist1.pop_front());
    endtask

    // One clock: advance the model on the edge, compare all outputs on the falling edge.
    task automatic cycle();
        logic [4:0] e;
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        e = {2'(m_state), m_tick, m_clear, (m_state == 1)};
        check("cycle", 32'({state, tick, clear, running}), 32'(e));
        seg_ticks  += int'(tick);
        seg_clears += int'(clear);
    endtask

    initial begin
        int n;
        int len;

        vecs[0]  = '{1'b1, 1'b1, 20, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1,  6, 1, 0, 0};
        vecs[2]  = '{1'b0, 1'b1,  8, 1, 2, 0};
        vecs[3]  = '{1'b1, 1'b1, 12, 1, 3, 0};
        vecs[4]  = '{1'b0, 1'b1,  3, 1, 0, 0};
        vecs[5]  = '{1'b0, 1'b1,  3, 2, 1, 0};
        vecs[6]  = '{1'b1, 1'b1, 20, 2, 0, 0};
        vecs[7]  = '{1'b0, 1'b1,  6, 1, 0, 0};
        vecs[8]  = '{1'b0, 1'b1,  2, 1, 1, 0};
        vecs[9]  = '{1'b1, 1'b1,  8, 1, 2, 0};
        vecs[10] = '{1'b0, 1'b1,  2, 1, 0, 0};
        vecs[11] = '{1'b1, 1'b1,  8, 1, 2, 0};
        vecs[12] = '{1'b0, 1'b1,  6, 2, 2, 0};
        vecs[13] = '{1'b1, 1'b1, 10, 2, 0, 0};
        vecs[14] = '{1'b0, 1'b0,  6, 0, 0, 1};
        vecs[15] = '{1'b1, 1'b1, 20, 0, 0, 0};

        model_reset();
        #1;
        check("reset_state", 32'({state, tick, clear, running}), 32'(0));
        repeat (3) cycle();
        reset = 1'b0;

        // Directed table: idle, run, pause with phase hold, glitch, run+clear together.
        for (int i = 0; i < 16; i++) begin
            btn_run_n   = vecs[i].run_n;
            btn_clear_n = vecs[i].clr_n;
            seg_ticks   = 0;
            seg_clears  = 0;
            repeat (vecs[i].cycles) cycle();
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_ticks", i), 32'(seg_ticks), 32'(vecs[i].exp_ticks));
            check($sformatf("vec%0d_clears", i), 32'(seg_clears), 32'(vecs[i].exp_clears));
        end

        // Reset two cycles into a run period, then a fresh full period after a new press.
        btn_run_n = 1'b0;
        n = 0;
        while (state != 2'd1 && n < 20) begin
            cycle();
            n++;
        end
        check("run_press_latency", 32'(n), 32'(2 + DB_CYCLES + 1));
        btn_run_n = 1'b1;
        repeat (2) cycle();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_async", 32'({state, tick, clear, running}), 32'(0));
        repeat (3) cycle();
        reset = 1'b0;
        repeat (10) cycle();
        check("idle_after_reset", 32'(state), 32'(0));
        btn_run_n = 1'b0;
        n = 0;
        while (state != 2'd1 && n < 20) begin
            cycle();
            n++;
        end
        check("rerun_press_latency", 32'(n), 32'(2 + DB_CYCLES + 1));
        n = 0;
        while (n < 2 * int'(CLK_DIV)) begin
            cycle();
            n++;
            if (tick) break;
        end
        check("first_tick_latency", 32'(n), 32'(CLK_DIV));
        btn_run_n = 1'b1;

        // Randomized key activity with occasional resets.
        for (int i = 0; i < 300; i++) begin
            btn_run_n   = 1'($urandom_range(0, 1));
            btn_clear_n = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            len         = int'($urandom_range(1, 10));
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                model_reset();
            end
            repeat (len) cycle();
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
